// File: rtl/serv_bufreg_vec.sv
`default_nettype none
// ============================================================================
// Module      : serv_bufreg_vec
// Description : Serial address/shift buffer register for a bit-serial RISC-V
//               core. It accumulates rs1 + imm one B-bit beat at a time,
//               shifts right for shift instructions, and applies a one-cycle
//               parallel signed stride for vector element addressing.
// Revision    : 1.0 - initial release
// ============================================================================
module serv_bufreg_vec #(
  parameter int B        = 1,   // serial bits per beat: 1, 2 or 4
  parameter int MDU      = 0,   // multiply/divide extension present
  parameter int VPU      = 0,   // vector extension present
  parameter int STRIDE_W = 12   // width of the signed stride operand
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cnt0,
  input  logic                i_en,
  input  logic                i_init,
  input  logic                i_mdu_op,
  input  logic                i_vpu_op,
  input  logic                i_rs1_en,
  input  logic                i_imm_en,
  input  logic                i_clr_lsb,
  input  logic                i_sh_signed,
  input  logic [B-1:0]        i_rs1,
  input  logic [B-1:0]        i_imm,
  input  logic                i_stride_en,
  input  logic [STRIDE_W-1:0] i_stride,
  output logic [B-1:0]        o_q,
  output logic [1:0]          o_lsb,
  output logic [31:0]         o_dbus_adr,
  output logic [31:0]         o_ext_rs1
);

  // Buffer register and serial carry. Only r_c[0] carries information; the
  // register keeps the beat width so the carry lines up with the datapath.
  logic [31:0]  r_d;
  logic [B-1:0] r_c;

  logic [B-1:0]  w_imm_mask;
  logic [B-1:0]  w_rs1_gated;
  logic [B-1:0]  w_imm_gated;
  logic [B:0]    w_sum;
  logic [B-1:0]  w_c_next;
  logic [B-1:0]  w_shift_fill;
  logic [31:0]   w_stride_ext;
  logic          w_lsb_zero;
  logic          w_unused_c;

  // JALR clears only bit 0 of the immediate, and only on the first beat.
  always_comb begin
    w_imm_mask    = '1;
    w_imm_mask[0] = ~(i_cnt0 & i_clr_lsb);
  end

  assign w_rs1_gated = i_rs1 & {B{i_rs1_en}};
  assign w_imm_gated = i_imm & {B{i_imm_en}} & w_imm_mask;

  // One beat of the serial adder; the carry-in is the previous beat's carry.
  assign w_sum = {1'b0, w_rs1_gated} + {1'b0, w_imm_gated} + {{B{1'b0}}, r_c[0]};

  // Carry-out lands in bit 0 of the carry register, upper bits stay zero.
  always_comb begin
    w_c_next    = '0;
    w_c_next[0] = w_sum[B];
  end

  // Arithmetic shifts replicate the current sign bit into every new bit.
  assign w_shift_fill = {B{r_d[31] & i_sh_signed}};

  // Sign-extend the stride to the full address width.
  generate
    if (STRIDE_W < 32) begin : g_stride_ext
      assign w_stride_ext = {{(32-STRIDE_W){i_stride[STRIDE_W-1]}}, i_stride};
    end else begin : g_stride_full
      assign w_stride_ext = i_stride[31:0];
    end
  endgenerate

  // Upper carry bits are always zero and never consumed.
  assign w_unused_c = ^r_c[B-1:1 % B] ^ r_c[0];

  // Buffer/carry update: reset first, then serial beats, then the stride.
  // A stride request on an enabled beat is simply dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_d <= '0;
      r_c <= '0;
    end else if (i_en) begin
      if (i_init) begin
        r_d <= {w_sum[B-1:0], r_d[31:B]};
        r_c <= w_c_next;
      end else begin
        r_d <= {w_shift_fill, r_d[31:B]};
      end
    end else begin
      // Idle cycles flush the carry so the next word starts clean.
      r_c <= '0;
      if (i_stride_en) begin
        r_d <= r_d + w_stride_ext;
      end
    end
  end

  // Extension operations address whole words, so they see a zero lsb.
  assign w_lsb_zero = ((MDU != 0) & i_mdu_op) | ((VPU != 0) & i_vpu_op);

  assign o_q        = r_d[B-1:0] & {B{i_en}};
  assign o_lsb      = w_lsb_zero ? 2'b00 : r_d[1:0];
  assign o_dbus_adr = {r_d[31:2], 2'b00};
  assign o_ext_rs1  = r_d;

endmodule
`default_nettype wire

// File: tb/tb_serv_bufreg_vec.sv
`default_nettype none
// ============================================================================
// Module      : tb_serv_bufreg_vec
// Description : Scoreboard bench for serv_bufreg_vec. Stimulus tasks push
//               expected outputs tagged with the cycle they apply to; a
//               monitor pops and compares them on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serv_bufreg_vec;

  localparam int B  = 2;
  localparam int SW = 12;
  localparam int NB = 32 / B;

  logic          i_clk = 1'b0;
  logic          i_rst, i_cnt0, i_en, i_init, i_mdu_op, i_vpu_op;
  logic          i_rs1_en, i_imm_en, i_clr_lsb, i_sh_signed, i_stride_en;
  logic [B-1:0]  i_rs1, i_imm;
  logic [SW-1:0] i_stride;
  logic [B-1:0]  o_q;
  logic [1:0]    o_lsb;
  logic [31:0]   o_dbus_adr, o_ext_rs1;

  always #5 i_clk = ~i_clk;

  serv_bufreg_vec #(.B(B), .MDU(1), .VPU(1), .STRIDE_W(SW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cnt0(i_cnt0), .i_en(i_en), .i_init(i_init),
    .i_mdu_op(i_mdu_op), .i_vpu_op(i_vpu_op), .i_rs1_en(i_rs1_en),
    .i_imm_en(i_imm_en), .i_clr_lsb(i_clr_lsb), .i_sh_signed(i_sh_signed),
    .i_rs1(i_rs1), .i_imm(i_imm), .i_stride_en(i_stride_en), .i_stride(i_stride),
    .o_q(o_q), .o_lsb(o_lsb), .o_dbus_adr(o_dbus_adr), .o_ext_rs1(o_ext_rs1)
  );

  typedef struct {
    int           cyc;
    bit           full;
    logic [31:0]  d;
    logic [1:0]   lsb;
    logic [B-1:0] q;
    string        tag;
  } exp_t;

  exp_t        sb[$];
  int          cyc   = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_d;   // reference value of the buffer register

  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic void chk(string tag, string fld, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s/%s at cycle %0d: got %h expected %h", tag, fld, cyc, got, want);
    end
  endfunction

  // Monitor: compare every expectation due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc != cyc) begin
          chk(e.tag, "stale", 32'(cyc), 32'(e.cyc));
        end else begin
          chk(e.tag, "q", 32'(o_q), 32'(e.q));
          if (e.full) begin
            chk(e.tag, "ext_rs1", o_ext_rs1, e.d);
            chk(e.tag, "dbus_adr", o_dbus_adr, e.d & 32'hFFFF_FFFC);
            chk(e.tag, "lsb", 32'(o_lsb), 32'(e.lsb));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Whole-state expectation for an idle cycle (i_en low, so o_q is zero).
  task automatic push_full(string tag);
    exp_t e;
    e.cyc = cyc; e.full = 1'b1; e.d = m_d; e.q = '0; e.tag = tag;
    e.lsb = (i_mdu_op || i_vpu_op) ? 2'b00 : m_d[1:0];
    sb.push_back(e);
  endtask

  task automatic push_beat(string tag, logic [B-1:0] q);
    exp_t e;
    e.cyc = cyc; e.full = 1'b0; e.d = '0; e.lsb = '0; e.q = q; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic idle(string tag, bit mdu, bit vpu);
    i_en = 1'b0; i_init = 1'b0; i_cnt0 = 1'b0; i_stride_en = 1'b0;
    i_mdu_op = mdu; i_vpu_op = vpu;
    push_full(tag);
    tick();
    i_mdu_op = 1'b0; i_vpu_op = 1'b0;
  endtask

  function automatic logic [31:0] sext(logic [SW-1:0] s);
    int v;
    v = int'($signed(s));
    return 32'(v);
  endfunction

  // Serial add word; if rst_beat >= 0 reset is asserted on that beat.
  task automatic init_word(string tag, logic [31:0] rs1, logic [31:0] imm,
                           bit rs1_en, bit imm_en, bit clr, int rst_beat, bit no_idle);
    logic [31:0] old, rv, iv;
    old = m_d;
    for (int k = 0; k < NB; k++) begin
      i_en = 1'b1; i_init = 1'b1; i_cnt0 = (k == 0);
      i_rs1_en = rs1_en; i_imm_en = imm_en; i_clr_lsb = clr;
      i_rs1 = rs1[k*B +: B]; i_imm = imm[k*B +: B];
      i_rst = (k == rst_beat);
      push_beat(tag, B'(old >> (k*B)));
      tick();
      if (k == rst_beat) begin
        i_rst = 1'b0;
        m_d = '0;
        if (!no_idle) idle({tag, "_rst"}, 1'b0, 1'b0);
        return;
      end
    end
    rv = rs1_en ? rs1 : 32'h0;
    iv = imm_en ? imm : 32'h0;
    if (clr) iv[0] = 1'b0;
    m_d = rv + iv;
    if (!no_idle) idle(tag, 1'b0, 1'b0);
  endtask

  // n shift beats; optional stride requests during the beats must be ignored.
  task automatic shift_word(string tag, int n, bit sgn, bit noise);
    logic [31:0] old;
    old = m_d;
    for (int k = 0; k < n; k++) begin
      i_en = 1'b1; i_init = 1'b0; i_cnt0 = (k == 0); i_sh_signed = sgn;
      i_rs1 = B'($urandom); i_imm = B'($urandom);
      i_stride_en = noise; i_stride = SW'($urandom);
      push_beat(tag, B'(old >> (k*B)));
      tick();
    end
    i_stride_en = 1'b0;
    m_d = sgn ? 32'($signed(old) >>> (n*B)) : (old >> (n*B));
    idle(tag, 1'b0, 1'b0);
  endtask

  task automatic stride_seq(string tag, logic [SW-1:0] s, int n);
    for (int k = 0; k < n; k++) begin
      i_en = 1'b0; i_init = 1'b0; i_stride_en = 1'b1; i_stride = s;
      push_full(tag);
      tick();
      m_d = m_d + sext(s);
    end
    idle(tag, 1'b0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1; i_cnt0 = 0; i_en = 0; i_init = 0; i_mdu_op = 0; i_vpu_op = 0;
    i_rs1_en = 0; i_imm_en = 0; i_clr_lsb = 0; i_sh_signed = 0; i_stride_en = 0;
    i_rs1 = '0; i_imm = '0; i_stride = '0;
    m_d = '0;
    tick();
    tick();
    i_rst = 1'b0;
    idle("reset", 1'b0, 1'b0);

    // Address add and carry flush between words
    init_word("add_1024", 32'h0000_1000, 32'h0000_0024, 1, 1, 0, -1, 0);
    init_word("wrap_zero", 32'hFFFF_FFFF, 32'h0000_0001, 1, 1, 0, -1, 0);
    init_word("no_stale_c", 32'h0000_0010, 32'h0000_0000, 1, 1, 0, -1, 0);
    init_word("gated_ops", 32'h1234_5678, 32'h0000_0FFF, 0, 1, 0, -1, 0);

    // JALR lsb clear, then extension ops force o_lsb to zero
    init_word("jalr", 32'h0000_0100, 32'h0000_0007, 1, 1, 1, -1, 0);
    idle("vpu_lsb", 1'b0, 1'b1);
    idle("mdu_lsb", 1'b1, 1'b0);
    init_word("no_clr", 32'h0000_0100, 32'h0000_0007, 1, 1, 0, -1, 0);

    // Arithmetic and logical right shifts by 4 bits
    init_word("ld_msb", 32'h8000_0000, 32'h0, 1, 1, 0, -1, 0);
    shift_word("sra4", 4 / B, 1'b1, 1'b0);
    init_word("ld_msb2", 32'h8000_0000, 32'h0, 1, 1, 0, -1, 0);
    shift_word("srl4", 4 / B, 1'b0, 1'b0);

    // Vector stride, negative stride, stride dropped while enabled, wrap
    init_word("ld_1000", 32'h0000_1000, 32'h0, 1, 1, 0, -1, 0);
    stride_seq("stride_p4", 12'h004, 3);
    stride_seq("stride_m4", 12'hFFC, 1);
    shift_word("stride_drop", 1, 1'b0, 1'b1);
    init_word("ld_top", 32'hFFFF_FFFE, 32'h0, 1, 1, 0, -1, 0);
    stride_seq("wrap_up", 12'h004, 1);
    init_word("ld_one", 32'h0000_0001, 32'h0, 1, 1, 0, -1, 0);
    stride_seq("wrap_dn", 12'hFFC, 1);

    // Reset mid-word: state cleared, then a word starts right away
    init_word("rst_mid", 32'hFFFF_FFFF, 32'h0000_0001, 1, 1, 0, 5, 0);
    init_word("rst_mid2", 32'hFFFF_FFFF, 32'h0000_0001, 1, 1, 0, 5, 1);
    init_word("after_rst", 32'h00AB_CDEF, 32'h0000_0011, 1, 1, 0, -1, 0);

    // Randomized mix of operations
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: init_word("rnd_add", $urandom, $urandom, 1'($urandom), 1'($urandom),
                     1'($urandom), -1, 0);
        1: shift_word("rnd_shift", $urandom_range(1, NB), 1'($urandom), 1'($urandom));
        2: stride_seq("rnd_stride", SW'($urandom), $urandom_range(1, 4));
        3: idle("rnd_idle", 1'($urandom), 1'($urandom));
        default: init_word("rnd_rst", $urandom, $urandom, 1, 1, 0,
                           $urandom_range(0, NB - 1), 0);
      endcase
    end

    tick();
    tick();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations never checked", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
